mul_datapath: RTL and testbench

Datapath for the team's repeated-addition multiplier; it is the responder to the multiplier control FSM. It executes the per-cycle commands `ldA`, `ldB`, `clrP`, `ldP` and `decB` and returns the `eqz` status flag that the controller polls. It computes `P = A * B` by adding `A` into `P` once per `B` decrement, and adds iteration counting, overflow and protocol-error reporting.

---
 rtl/mul_datapath.sv | 103 ++++++++++
 tb/tb_mul_datapath.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_datapath.sv
// ============================================================================
// Module   : mul_datapath
// Brief    : Repeated-addition multiplier datapath (P = A * B), with iteration
//            count, sticky overflow and sticky protocol-error flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_datapath #(
  parameter int DW = 16,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic          ldA,
  input  logic          ldB,
  input  logic          clrP,
  input  logic          ldP,
  input  logic          decB,
  output logic          eqz,
  output logic [PW-1:0] p_out,
  output logic [DW-1:0] iter,
  output logic          ovf,
  output logic          err
);

  localparam logic [DW-1:0] c_one = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [PW-1:0] r_p;
  logic [DW-1:0] r_iter;
  logic          r_ovf;
  logic          r_err;

  logic          w_b_nz;
  logic [PW:0]   w_a_ext;
  logic [PW:0]   w_sum;
  logic          w_acc;
  logic          w_dec;
  logic          w_illegal;

  // Gating uses the pre-edge B so ldP+decB together give exactly B0 adds.
  assign w_b_nz    = (r_b != '0);
  assign w_a_ext   = {{(PW+1-DW){1'b0}}, r_a};
  assign w_sum     = {1'b0, r_p} + w_a_ext;
  assign w_acc     = ldP && !clrP && w_b_nz;
  assign w_dec     = decB && !ldB && w_b_nz;
  assign w_illegal = (clrP && ldP) || (ldB && decB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (ldA) begin
        r_a <= a_in;
      end
      if (ldB) begin
        r_b <= b_in;
      end else if (w_dec) begin
        r_b <= r_b - c_one;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p    <= '0;
      r_iter <= '0;
      r_ovf  <= 1'b0;
    end else if (clrP) begin
      r_p    <= '0;
      r_iter <= '0;
      r_ovf  <= 1'b0;
    end else if (w_acc) begin
      r_p    <= w_sum[PW-1:0];
      r_iter <= r_iter + c_one;
      if (w_sum[PW]) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_illegal) begin
      r_err <= 1'b1;
    end
  end

  assign eqz   = !w_b_nz;
  assign p_out = r_p;
  assign iter  = r_iter;
  assign ovf   = r_ovf;
  assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mul_datapath.sv
// ============================================================================
// Module   : tb_mul_datapath
// Brief    : Self-checking bench for mul_datapath; directed scenarios plus
//            randomized multiplies against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        ldA, ldB, clrP, ldP, decB;
  logic        eqz;
  logic [15:0] p_out;
  logic [15:0] iter;
  logic        ovf;
  logic        err;

  int checks = 0;
  int errors = 0;

  mul_datapath #(.DW(16), .PW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a_in  (a_in),
    .b_in  (b_in),
    .ldA   (ldA),
    .ldB   (ldB),
    .clrP  (clrP),
    .ldP   (ldP),
    .decB  (decB),
    .eqz   (eqz),
    .p_out (p_out),
    .iter  (iter),
    .ovf   (ovf),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic la, input logic lb, input logic cp,
                       input logic lp, input logic db);
    ldA = la; ldB = lb; clrP = cp; ldP = lp; decB = db;
  endtask

  task automatic test_reset_state();
    checks++;
    if (p_out !== 16'h0 || iter !== 16'h0 || eqz !== 1'b1 || ovf !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: p=%h iter=%0d eqz=%b ovf=%b err=%b, want p=0 iter=0 eqz=1 ovf=0 err=0",
               p_out, iter, eqz, ovf, err);
    end
  endtask

  task automatic test_basic();
    a_in = 16'd7; b_in = 16'd5;
    drive(1, 1, 0, 0, 0); tick();
    checks++;
    if (eqz !== 1'b0) begin errors++; $display("FAIL basic_load_eqz: eqz=%b want 0", eqz); end
    drive(0, 0, 1, 0, 0); tick();
    for (int i = 1; i <= 6; i++) begin
      drive(0, 0, 0, 1, 1); tick();
      checks++;
      if (eqz !== (i >= 5)) begin
        errors++; $display("FAIL basic_eqz_cycle%0d: eqz=%b want %b", i, eqz, (i >= 5));
      end
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (p_out !== 16'd35 || iter !== 16'd5 || ovf !== 1'b0) begin
      errors++; $display("FAIL basic_result: p=%0d iter=%0d ovf=%b want p=35 iter=5 ovf=0", p_out, iter, ovf);
    end
  endtask

  task automatic test_zero_operand();
    a_in = 16'd9; b_in = 16'd0;
    drive(1, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 1); tick();
      checks++;
      if (eqz !== 1'b1 || p_out !== 16'd0 || iter !== 16'd0) begin
        errors++; $display("FAIL zero_b_cycle%0d: eqz=%b p=%0d iter=%0d want 1/0/0", i, eqz, p_out, iter);
      end
    end
    a_in = 16'd0; b_in = 16'd4;
    drive(1, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 1); tick();
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (p_out !== 16'd0 || iter !== 16'd4 || eqz !== 1'b1) begin
      errors++; $display("FAIL zero_a: p=%0d iter=%0d eqz=%b want 0/4/1", p_out, iter, eqz);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_p [3];
    logic        exp_o [3];
    exp_p[0] = 16'hFFFF; exp_p[1] = 16'hFFFE; exp_p[2] = 16'hFFFD;
    exp_o[0] = 1'b0;     exp_o[1] = 1'b1;     exp_o[2] = 1'b1;
    a_in = 16'hFFFF; b_in = 16'd3;
    drive(1, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 1); tick();
      checks++;
      if (p_out !== exp_p[i] || ovf !== exp_o[i]) begin
        errors++; $display("FAIL ovf_acc%0d: p=%h ovf=%b want p=%h ovf=%b", i + 1, p_out, ovf, exp_p[i], exp_o[i]);
      end
    end
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (ovf !== 1'b0 || p_out !== 16'd0) begin
      errors++; $display("FAIL ovf_clear: ovf=%b p=%h want 0/0", ovf, p_out);
    end
  endtask

  task automatic test_illegal();
    a_in = 16'd2; b_in = 16'd3;
    drive(1, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 0); tick();
    checks++;
    if (p_out !== 16'd2 || err !== 1'b0) begin
      errors++; $display("FAIL illegal_pre: p=%0d err=%b want 2/0", p_out, err);
    end
    drive(0, 0, 1, 1, 0); tick();
    checks++;
    if (p_out !== 16'd0 || iter !== 16'd0 || err !== 1'b1) begin
      errors++; $display("FAIL illegal_clr_ld: p=%0d iter=%0d err=%b want 0/0/1", p_out, iter, err);
    end
    // B must come out as 6 (not 5): confirmed by counting accumulations.
    b_in = 16'd6;
    drive(0, 1, 0, 0, 1); tick();
    a_in = 16'd1;
    drive(1, 0, 1, 0, 0); tick();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 1, 1); tick();
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (iter !== 16'd6 || p_out !== 16'd6 || err !== 1'b1) begin
      errors++; $display("FAIL illegal_ldb_decb: iter=%0d p=%0d err=%b want 6/6/1", iter, p_out, err);
    end
  endtask

  task automatic test_async_reset();
    a_in = 16'h0123; b_in = 16'd1;
    drive(1, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (p_out !== 16'h0123) begin
      errors++; $display("FAIL areset_pre: p=%h want 0123", p_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (p_out !== 16'h0 || eqz !== 1'b1 || ovf !== 1'b0 || err !== 1'b0 || iter !== 16'h0) begin
      errors++; $display("FAIL areset: p=%h eqz=%b ovf=%b err=%b iter=%0d want 0/1/0/0/0", p_out, eqz, ovf, err, iter);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    a_in = 16'd3; b_in = 16'd4;
    drive(1, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1); tick();
    end
    checks++;
    if (p_out !== 16'd12 || iter !== 16'd4) begin
      errors++; $display("FAIL b2b_first: p=%0d iter=%0d want 12/4", p_out, iter);
    end
    a_in = 16'd10; b_in = 16'd2;
    drive(1, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    checks++;
    if (p_out !== 16'd0 || iter !== 16'd0) begin
      errors++; $display("FAIL b2b_clear: p=%0d iter=%0d want 0/0", p_out, iter);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 1); tick();
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (p_out !== 16'd20 || iter !== 16'd2 || eqz !== 1'b1) begin
      errors++; $display("FAIL b2b_second: p=%0d iter=%0d eqz=%b want 20/2/1", p_out, iter, eqz);
    end
  endtask

  // Reference: product, count and overflow follow from a*b directly.
  task automatic test_random();
    int unsigned a, b, extra;
    longint unsigned prod;
    logic [15:0] exp_p;
    logic        exp_ovf;
    for (int t = 0; t < 25; t++) begin
      a     = $urandom_range(0, 65535);
      b     = $urandom_range(0, 12);
      extra = $urandom_range(0, 3);
      prod    = longint'(a) * longint'(b);
      exp_p   = prod[15:0];
      exp_ovf = (prod > 64'd65535);
      a_in = a[15:0]; b_in = b[15:0];
      drive(1, 1, 0, 0, 0); tick();
      drive(0, 0, 1, 0, 0); tick();
      for (int k = 1; k <= int'(b + extra); k++) begin
        drive(0, 0, 0, 1, 1); tick();
        checks++;
        if (eqz !== (k >= int'(b))) begin
          errors++; $display("FAIL rand%0d_eqz_k%0d: eqz=%b want %b (b=%0d)", t, k, eqz, (k >= int'(b)), b);
        end
      end
      drive(0, 0, 0, 0, 0); tick();
      checks++;
      if (p_out !== exp_p || iter !== b[15:0] || ovf !== exp_ovf || eqz !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d_result: a=%0d b=%0d p=%h iter=%0d ovf=%b eqz=%b want p=%h iter=%0d ovf=%b eqz=1",
                 t, a, b, p_out, iter, ovf, eqz, exp_p, b, exp_ovf);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_in  = '0;
    b_in  = '0;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    test_reset_state();
    rst_n = 1'b1;
    test_basic();
    test_zero_operand();
    test_overflow();
    test_illegal();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
